// File: rtl/sevenseg_scan_ctrl_if.sv
// Bus between the application registers, the scan controller and the shared
// seven-segment driver: digit data in, driver data and digit selects out.
interface sevenseg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dots;
  logic                lz_suppress;
  logic [7:0]          drv_data;
  logic                drv_en;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_done;

  modport master (
    output value, dots, lz_suppress,
    input  drv_data, drv_en, dig_sel, frame_done
  );

  modport slave (
    input  value, dots, lz_suppress,
    output drv_data, drv_en, dig_sel, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: snapshots a multi-digit value
// once per frame and steps through the digits with a blanking gap between them.
module sevenseg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int BLANK_TICKS = 1,
  parameter int SHOW_TICKS  = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 tick,
  sevenseg_scan_ctrl_if.slave  bus
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXT = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t              state;
  logic                en_meta;
  logic                en_s;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dots;

  logic [7:0]          drv_data_q;
  logic                drv_en_q;
  logic [DIGITS-1:0]   dig_sel_q;
  logic                frame_done_q;

  logic [3:0]          cur_nibble;
  logic                cur_dot;
  logic [DIGITS-1:0]   cur_sel;
  logic                upper_zero;
  logic                suppress;
  logic [7:0]          cur_data;

  // A digit is a leading zero when it and every more significant digit and dot are blank.
  always_comb begin
    cur_nibble = '0;
    cur_dot    = 1'b0;
    cur_sel    = '0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      cur_sel[k] = (k == int'(idx));
      if (k == int'(idx)) begin
        cur_nibble = snap_value[4*k +: 4];
        cur_dot    = snap_dots[k];
      end
      if ((k >= int'(idx)) && ((snap_value[4*k +: 4] != 4'h0) || snap_dots[k])) begin
        upper_zero = 1'b0;
      end
    end
    suppress = bus.lz_suppress && (idx != '0) && upper_zero;
    cur_data = {cur_dot, 3'b000, cur_nibble};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      en_meta      <= 1'b0;
      en_s         <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      snap_value   <= '0;
      snap_dots    <= '0;
      drv_data_q   <= '0;
      drv_en_q     <= 1'b0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else if (reset) begin
      state        <= IDLE;
      en_meta      <= 1'b0;
      en_s         <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      snap_value   <= '0;
      snap_dots    <= '0;
      drv_data_q   <= '0;
      drv_en_q     <= 1'b0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      en_meta      <= en;
      en_s         <= en_meta;
      frame_done_q <= 1'b0;
      // Losing enable abandons the frame immediately, even if a tick arrives on the same edge.
      if (!en_s) begin
        state      <= IDLE;
        idx        <= '0;
        cnt        <= '0;
        drv_data_q <= '0;
        drv_en_q   <= 1'b0;
        dig_sel_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            snap_value <= bus.value;
            snap_dots  <= bus.dots;
            idx        <= '0;
            cnt        <= '0;
            state      <= BLANK;
          end
          BLANK: begin
            if (tick) begin
              if (cnt == BLANK_LAST) begin
                cnt        <= '0;
                state      <= SHOW;
                drv_data_q <= cur_data;
                drv_en_q   <= !suppress;
                dig_sel_q  <= suppress ? '0 : cur_sel;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          SHOW: begin
            if (tick) begin
              if (cnt == SHOW_LAST) begin
                cnt       <= '0;
                state     <= BLANK;
                drv_en_q  <= 1'b0;
                dig_sel_q <= '0;
                // The last digit closes the frame and takes a fresh snapshot of the live inputs.
                if (idx == LAST_IDX) begin
                  idx          <= '0;
                  frame_done_q <= 1'b1;
                  snap_value   <= bus.value;
                  snap_dots    <= bus.dots;
                end else begin
                  idx <= idx + 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.drv_data   = drv_data_q;
  assign bus.drv_en     = drv_en_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexing scan controller that shares one seven-segment driver (8-bit data in, a..g + dp out) between DIGITS common-select digit positions.
- Snapshots a multi-digit value once per frame and steps through the digits on timer ticks, inserting a blanking gap between digits to prevent ghosting.
- Drives the shared driver's data input and the per-digit select lines.
- Sits between the application registers and the seven-segment driver, using the same tick/en/reset/aresetn/aclk system signals.

Parameters:
- DIGITS, 4: number of multiplexed digit positions, 2..8.
- BLANK_TICKS, 1: ticks with all digits deselected before each digit, >=1.
- SHOW_TICKS, 4: ticks each digit is displayed, >=1.

Ports:
- aclk  in  1  clock, 20 MHz, rising edge.
- aresetn  in  1  asynchronous reset, active low.
- reset  in  1  synchronous reset, active high, synchronous to aclk.
- en  in  1  enable, asynchronous to aclk, active high.
- tick  in  1  one-aclk pulse every N cycles.
- value  in  4*DIGITS  nibble per digit; nibble k = digit k, and digit 0 is least significant.
- dots  in  DIGITS  decimal point per digit.
- lz_suppress  in  1  blank leading zeros when 1.
- drv_data  out  8  to the driver: [3:0] nibble, [7] dot, [6:4] always 0.
- drv_en  out  1  enable to the driver.
- dig_sel  out  DIGITS  one-hot digit select, active high; all zero means blank.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- All outputs are registered.
- Reset state: on aresetn low (async) or reset high (sync, overrides all other inputs):
  - drv_data=0, drv_en=0, dig_sel=0, frame_done=0.
  - FSM=IDLE; digit index=0; tick counter=0; snapshot=0; enable synchronizer cleared.
- en passes through a 2-FF synchronizer (en_s). Changes on en reach the FSM 2 aclk cycles later.
- Tick counter:
  - Increments only on cycles where tick=1.
  - A state's duration is complete on the aclk edge where tick=1 and count equals (duration-1). The counter clears on every state change.
- FSM states:
  - IDLE: outputs zero. When en_s=1: latch value/dots into the snapshot, set index=0, go to BLANK.
  - BLANK: dig_sel=0, drv_en=0, drv_data holds its previous value. After BLANK_TICKS ticks go to SHOW.
  - SHOW:
    - drv_data = {dot[idx],3'b000,nibble[idx]} from the snapshot; drv_en=1; dig_sel=onehot(idx), except when the digit is suppressed.
    - After SHOW_TICKS ticks: if idx<DIGITS-1, set idx+1 and go to BLANK.
    - Otherwise set idx=0, pulse frame_done for exactly one aclk cycle, re-latch the snapshot from the live inputs on that same edge, and go to BLANK.
- Output latency: outputs change on the same aclk edge as the state transition, i.e. the edge sampling the qualifying tick.
- Snapshot:
  - Live value/dots changes mid-frame are not displayed until the next frame boundary.
  - Frame period = DIGITS*(BLANK_TICKS+SHOW_TICKS) ticks.
- Leading-zero suppression:
  - Applies when lz_suppress=1 (sampled live) and idx>0.
  - A digit is suppressed when the snapshot nibbles idx..DIGITS-1 are all 0 and dots idx..DIGITS-1 are all 0.
  - Suppressed slot: dig_sel=0 and drv_en=0 for that slot, but the slot's time is still consumed.
  - Digit 0 is never suppressed.
- en_s falling in any state: on the next aclk edge go to IDLE with all outputs 0; index, counter and frame_done cleared. Any in-progress frame is abandoned without a frame_done pulse.
- A tick coinciding with en_s falling: the disable wins.
- Reset mid-frame: immediate return to the reset state above; no frame_done pulse.
- At most one bit of dig_sel is high at any time. dig_sel never changes directly from one digit to another; at least one BLANK interval always lies between them.

Test Plan (DIGITS=4, BLANK_TICKS=1, SHOW_TICKS=2, tick every 4 aclk):
- Basic scan: value=16'h1234, dots=4'b0000, en=1.
  - Required: dig_sel sequence 0000, 0001 (drv_data=8'h04), 0000, 0010 (8'h03), 0000, 0100 (8'h02), 0000, 1000 (8'h01).
  - Each SHOW lasts 2 ticks. frame_done pulses once every 12 ticks, for 1 cycle.
- Snapshot: change value 16'h1234 to 16'hABCD while idx=1.
  - Required: the rest of the frame still shows 3, 2, 1; the next frame shows D, C, B, A.
- Leading zeros: value=16'h0050, dots=0, lz_suppress=1.
  - Required: digits 3 and 2 have dig_sel=0 and drv_en=0; digit 1 shows 8'h05; digit 0 shows 8'h00.
  - Repeat with dots=4'b0100: required digit 2 shows 8'h80 and digit 3 stays blank.
- Disable mid-frame: drop en during SHOW of idx=2.
  - Required: all outputs 0 within 3 aclk cycles, no frame_done.
  - Re-assert en: the scan restarts at BLANK with idx=0 and a fresh snapshot.
- Resets:
  - Assert aresetn=0 between clock edges: required all outputs 0 immediately, without waiting for an edge.
  - Assert reset=1 together with tick=1 during SHOW: required reset state on the next edge, and the scan resumes from IDLE after reset is released.
- Invariant checks (throughout all scenarios): dig_sel is always one-hot or zero; there is always at least 1 tick of all-zero dig_sel between different digits; drv_data[6:4] is always 0.
